// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply / unsigned divide for the EX stage.
//   MUL  : shift-add, returns the low WIDTH bits of a*b.
//   UDIV : restoring division, returns a/b (0 when b == 0).
// Every operation takes exactly WIDTH iterations after the start edge.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-low
//   start_mult  begin MUL (wins over start_div)
//   start_div   begin UDIV
//   flush       squash the in-flight op / block a new start
//   a, b        operands, sampled on the start edge
//   stall       combinational pipeline hold
//   done        registered one-cycle result-valid pulse
//   result      registered, last completed result
module muldiv_unit #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc, mcand, mplier;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo, dvsr;

  logic             accept, busy, last;
  logic [WIDTH-1:0] mul_sum;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH+1:0] div_diff;
  logic             div_ok;
  logic [WIDTH:0]   div_rem_nxt;
  logic [WIDTH-1:0] div_quo_nxt;

  assign accept = ((state == IDLE) || (state == DONE)) && !flush && (start_mult || start_div);
  assign busy   = (state == MUL) || (state == DIV);
  assign last   = (cnt == CW'(WIDTH-1));
  assign stall  = accept || busy;

  // One shift-add step; bits above WIDTH are simply dropped.
  assign mul_sum = acc + (mplier[0] ? mcand : '0);

  // One restoring step. The remainder stays below the divisor, so the
  // WIDTH+2-bit difference has a valid sign bit in its MSB.
  assign div_sh      = {rem[WIDTH-1:0], quo[WIDTH-1]};
  assign div_diff    = {rem, quo[WIDTH-1]} - {2'b00, dvsr};
  assign div_ok      = !div_diff[WIDTH+1];
  assign div_rem_nxt = div_ok ? div_diff[WIDTH:0] : div_sh;
  assign div_quo_nxt = {quo[WIDTH-2:0], div_ok};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (accept)
          state_nxt = start_mult ? MUL : DIV;
        else
          state_nxt = IDLE;
      end
      MUL, DIV: begin
        if (flush)
          state_nxt = IDLE;
        else if (last)
          state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      rem    <= '0;
      quo    <= '0;
      dvsr   <= '0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        // Both datapaths load; only the selected one iterates.
        cnt    <= '0;
        acc    <= '0;
        mcand  <= a;
        mplier <= b;
        rem    <= '0;
        quo    <= a;
        dvsr   <= b;
      end else if (busy && !flush) begin
        cnt <= cnt + CW'(1);
        if (state == MUL) begin
          acc    <= mul_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
        end else begin
          rem <= div_rem_nxt;
          quo <= div_quo_nxt;
        end
        if (last) begin
          done <= 1'b1;
          if (state == MUL)
            result <= mul_sum;
          else
            result <= (dvsr == '0) ? '0 : div_quo_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a vector table of single operations plus
// hand-written flush, reset, start-priority and back-to-back sequences.
module tb_muldiv_unit;

  localparam int W = 64;

  logic          clk, reset, start_mult, start_div, flush;
  logic [W-1:0]  a, b, result;
  logic          stall, done;

  int nvec = 0;
  int nbad = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start_mult(start_mult), .start_div(start_div),
    .flush(flush), .a(a), .b(b), .stall(stall), .done(done), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;   // bit0 start_mult, bit1 start_div
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive a start for one cycle beginning at the next falling edge.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    start_mult = op[0];
    start_div  = op[1];
    a = av;
    b = bv;
    #1;
  endtask

  // Count falling edges until done; lat = edges from start edge to done.
  task automatic wait_done(input int stc0, output int lat, output int stc);
    stc = stc0;
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      start_mult = 1'b0;
      start_div  = 1'b0;
      #1;
      if (done) begin
        lat = k - 1;
        break;
      end
      if (stall) stc++;
    end
  endtask

  initial begin
    int lat, stc, st0, seen;
    logic [W-1:0] prev;

    vecs[0] = '{2'b01, 64'd7, 64'd6, 64'd42};
    vecs[1] = '{2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[2] = '{2'b10, 64'd100, 64'd7, 64'd14};
    vecs[3] = '{2'b10, 64'h8000_0000_0000_0000, 64'd3, 64'h2AAA_AAAA_AAAA_AAAA};
    vecs[4] = '{2'b10, 64'd5, 64'd0, 64'd0};
    vecs[5] = '{2'b10, 64'd3, 64'd7, 64'd0};
    vecs[6] = '{2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1};
    vecs[7] = '{2'b01, 64'h1_0000_0000, 64'h1_0000_0000, 64'd0};
    vecs[8] = '{2'b11, 64'd9, 64'd3, 64'd27};

    reset = 1'b0; start_mult = 1'b0; start_div = 1'b0; flush = 1'b0;
    a = '0; b = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_result", result, '0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_stall", {63'd0, stall}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    prev = '0;
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      st0 = stall ? 1 : 0;
      wait_done(st0, lat, stc);
      chk($sformatf("v%0d_result", i), result, vecs[i].exp);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'd64);
      chk($sformatf("v%0d_stalls", i), 64'(stc), 64'd65);
      chk($sformatf("v%0d_stall_in_done", i), {63'd0, stall}, 64'd0);
      @(negedge clk);
      #1;
      chk($sformatf("v%0d_done_clears", i), {63'd0, done}, 64'd0);
      chk($sformatf("v%0d_result_held", i), result, vecs[i].exp);
      prev = vecs[i].exp;
    end

    // Flush during iteration 10 of MUL 3x3: back to IDLE, no pulse.
    issue(2'b01, 64'd3, 64'd3);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start_mult = 1'b0;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_stall", {63'd0, stall}, 64'd0);
    chk("flush_result", result, prev);
    seen = 0;
    repeat (70) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("flush_no_done", 64'(seen), 64'd0);
    chk("flush_result_kept", result, prev);

    // Flush beats a start in IDLE.
    @(negedge clk);
    start_mult = 1'b1; flush = 1'b1; a = 64'd2; b = 64'd2;
    #1;
    chk("flush_prio_stall", {63'd0, stall}, 64'd0);
    @(negedge clk);
    start_mult = 1'b0; flush = 1'b0;
    #1;
    chk("flush_prio_idle", {63'd0, stall}, 64'd0);

    // Reset in the middle of a DIV.
    issue(2'b10, 64'd100, 64'd7);
    repeat (20) begin
      @(negedge clk);
      start_div = 1'b0;
    end
    reset = 1'b0;
    #1;
    chk("midrst_result", result, '0);
    chk("midrst_stall", {63'd0, stall}, 64'd0);
    chk("midrst_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (70) begin
      @(negedge clk);
      if (done || stall) seen++;
    end
    chk("midrst_quiet", 64'(seen), 64'd0);

    // Back-to-back: MUL 4x5, then DIV 20/4 started in the DONE cycle.
    issue(2'b01, 64'd4, 64'd5);
    wait_done(1, lat, stc);
    chk("b2b_first_result", result, 64'd20);
    chk("b2b_first_latency", 64'(lat), 64'd64);
    start_div = 1'b1; a = 64'd20; b = 64'd4;
    #1;
    chk("b2b_start_stall", {63'd0, stall}, 64'd1);
    wait_done(1, lat, stc);
    chk("b2b_second_result", result, 64'd5);
    chk("b2b_second_latency", 64'(lat), 64'd64);
    chk("b2b_second_stalls", 64'(stc), 64'd65);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 64-bit multiply/divide unit in the execute stage of the in-order pipeline, beside the ALU. It consumes the `mult`/`div` strobes and the two register operands for the instruction in EX. It stalls the pipeline while it iterates, then returns a result that the EX result mux selects when `whichMath` = 2 or 3. MUL returns the low WIDTH bits of the product; UDIV returns the unsigned quotient.

## Interface
- `WIDTH`, 64: operand/result width; also the iteration count.
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: one clock; reset is asynchronous and active-low.
- `start_mult`  in  1: EX instruction is MUL (from control `mult`).
- `start_div`  in  1: EX instruction is UDIV (from control `div`).
- `flush`  in  1: squash the in-flight operation (branch redirect).
- `a`  in  WIDTH: operand Rn (multiplicand / dividend), sampled at start.
- `b`  in  WIDTH: operand Rm (multiplier / divisor), sampled at start.
- `stall`  out  1: combinational; hold PC and IF/ID/EX registers.
- `done`  out  1: registered; one-cycle result-valid pulse.
- `result`  out  WIDTH: registered; last completed result, held until overwritten.

## Operation
- States: IDLE, MUL, DIV, DONE. Reset state is IDLE with `result`=0, `done`=0 and iteration count 0. Internal operand and accumulator registers reset to 0.
- Accept: in IDLE or DONE, with `flush`=0:
  - `start_mult`=1 loads and goes to MUL.
  - Otherwise `start_div`=1 loads and goes to DIV.
  - MUL has priority if both are high.
  - The start level is ignored in MUL/DIV.
- MUL (shift-add):
  - Load: accumulator 0, multiplicand=`a`, multiplier=`b`.
  - Each cycle: if multiplier[0]=1, add multiplicand to accumulator mod 2^WIDTH. Then shift multiplicand left 1 and multiplier right 1.
  - Upper product bits are discarded.
- DIV (unsigned restoring):
  - Load: remainder (WIDTH+1 bits) = 0, quotient register = `a`, divisor = `b`.
  - Each cycle: shift {remainder, quotient} left 1 and trial-subtract the divisor.
  - If the trial is non-negative, keep the difference and set quotient[0]=1. Otherwise restore and set quotient[0]=0.
- Divide by zero: the iterations still run, but `result` is forced to 0 (ARM UDIV semantics). Latency is unchanged.
- Iteration count runs 0..WIDTH-1. On the iteration with count = WIDTH-1:
  - go to DONE;
  - write `result`;
  - set `done`=1.
- DONE lasts one cycle. `done` clears on the next edge. The next state is IDLE, or MUL/DIV if a new start is accepted.
- `stall` = (start_mult|start_div) & state∈{IDLE,DONE} & ~flush, OR state∈{MUL,DIV}. It is never asserted in DONE without a new start.
- Flush: `flush`=1 in MUL/DIV returns to IDLE on the next edge. There is no `done` pulse and `result` is unchanged. `flush` has priority over a simultaneous start.
- Reset mid-operation: immediately goes to IDLE with `result`=0 and `done`=0. No pulse follows reset release.

## Timing
- Start sampled at edge E0. Iterations occur on edges E1..E_WIDTH.
- `done`=1 and `result` are valid from E_WIDTH to E_WIDTH+1.
- `stall` is high from the start cycle until E_WIDTH, which is WIDTH+1 stalled cycles in total. It is low in the DONE cycle, so the instruction advances with `result`.
- Latency is fixed at WIDTH cycles from the start edge to `done`, independent of operand values.
- Back-to-back: a start in the DONE cycle begins the next op at E_WIDTH+1 with no idle bubble. `done` then goes low for WIDTH cycles.
- `result` changes only on a completing edge or on reset.

## Test plan
- MUL: `a`=7, `b`=6 → `stall` high for 65 cycles, then `done` pulses once with `result`=42.
- MUL wrap: `a`=0xFFFF_FFFF_FFFF_FFFF, `b`=2 → `result`=0xFFFF_FFFF_FFFF_FFFE.
- DIV: `a`=100, `b`=7 → `result`=14, 64 cycles after the start edge. Also `a`=0x8000_0000_0000_0000, `b`=3 → `result`=0x2AAA_AAAA_AAAA_AAAA.
- Divide by zero: `a`=5, `b`=0 → `done` arrives at the normal latency with `result`=0. Start with `start_mult`=`start_div`=1 → MUL performed.
- Flush at iteration 10 of a MUL 3×3 → IDLE, no `done`, `result` keeps its prior value. Reset asserted mid-DIV → `result`=0 and `stall`=0 immediately.
- Back-to-back: MUL 4×5 followed by a start in the DONE cycle of DIV 20/4 → `done` pulses with 20, then 64 cycles later with 5.
